// File: rtl/forward_stall_ctrl.sv
// forward_stall_ctrl: executes decode's hazard decisions.
//   - Drives PC / IF-ID enables and the ID-EX bubble (combinational).
//   - Owns the ID-EX forwarding-select register and the one-cycle load-use stall FSM.
//   - Holds the result / load history and muxes the forwarded EX operands.
// Optional: define STALL_COUNT_EN to add a saturating 16-bit stall counter output.
module forward_stall_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic [3:0]        mux_ctrl,
    input  logic              flush,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] op1_rf,
    input  logic [DATA_W-1:0] op2_rf,
    output logic [DATA_W-1:0] op1_out,
    output logic [DATA_W-1:0] op2_out,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_nop,
    output logic [3:0]        fwd_sel
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic {RUN, STALL} state_t;

    state_t            state;
    logic [3:0]        pend_sel;
    logic [DATA_W-1:0] res_q1;
    logic [DATA_W-1:0] res_q2;
    logic [DATA_W-1:0] ld_q;

    // A stall only starts from RUN, and flush overrides the freeze request.
    logic stall_start;
    assign stall_start = (state == RUN) && !flush && freeze;

    // Load-use codes are rewritten to the ld_q source the bubble cycle will capture.
    function automatic logic [3:0] remap_ld(input logic [3:0] code);
        case (code)
            4'd5:    remap_ld = 4'd7;
            4'd6:    remap_ld = 4'd8;
            default: remap_ld = 4'd0;
        endcase
    endfunction

    // Only codes with a defined operand source are forwarded; the rest read the RF.
    function automatic logic [3:0] legal_fwd(input logic [3:0] code);
        case (code)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8: legal_fwd = code;
            default:                                  legal_fwd = 4'd0;
        endcase
    endfunction

    // Stall FSM, forwarding-select register and history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            fwd_sel  <= 4'd0;
            pend_sel <= 4'd0;
            res_q1   <= '0;
            res_q2   <= '0;
            ld_q     <= '0;
        end else begin
            // History keeps moving through stalls so ld_q holds the bubble-cycle load data.
            res_q1 <= ex_result;
            res_q2 <= res_q1;
            ld_q   <= mem_rdata;
            case (state)
                RUN: begin
                    if (flush) begin
                        fwd_sel  <= 4'd0;
                        pend_sel <= 4'd0;
                    end else if (freeze) begin
                        fwd_sel  <= 4'd0;
                        pend_sel <= remap_ld(mux_ctrl);
                        state    <= STALL;
                    end else begin
                        fwd_sel  <= legal_fwd(mux_ctrl);
                    end
                end
                STALL: begin
                    // Decode inputs are ignored here; the held code is released or killed.
                    fwd_sel  <= flush ? 4'd0 : pend_sel;
                    pend_sel <= 4'd0;
                    state    <= RUN;
                end
                default: begin
                    fwd_sel  <= 4'd0;
                    pend_sel <= 4'd0;
                    state    <= RUN;
                end
            endcase
        end
    end

    // Pipeline enables follow the current state and this cycle's hazard inputs.
    always_comb begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_nop = 1'b0;
        if (state == RUN) begin
            if (flush) begin
                idex_nop = 1'b1;
            end else if (freeze) begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_nop = 1'b1;
            end
        end else begin
            idex_nop = flush;
        end
    end

    // EX operand select: the operand not named by the code comes from the RF.
    always_comb begin
        op1_out = op1_rf;
        op2_out = op2_rf;
        case (fwd_sel)
            4'd1:    op1_out = res_q1;
            4'd2:    op2_out = res_q1;
            4'd3:    op1_out = res_q2;
            4'd4:    op2_out = res_q2;
            4'd7:    op1_out = ld_q;
            4'd8:    op2_out = ld_q;
            default: ;
        endcase
    end

`ifdef STALL_COUNT_EN
    // Counts RUN->STALL transitions, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (stall_start && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_forward_stall_ctrl.sv
// Directed bench for forward_stall_ctrl; expected values are hand-computed.
// Inputs change 1 time unit after the rising edge, outputs are checked 2 units later.
module tb_forward_stall_ctrl;

    localparam int DATA_W = 16;
    localparam logic [15:0] RF1 = 16'hA1A1;
    localparam logic [15:0] RF2 = 16'hB2B2;

    logic              clk = 1'b0;
    logic              rst;
    logic              freeze;
    logic [3:0]        mux_ctrl;
    logic              flush;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] op1_rf;
    logic [DATA_W-1:0] op2_rf;
    logic [DATA_W-1:0] op1_out;
    logic [DATA_W-1:0] op2_out;
    logic              pc_en;
    logic              ifid_en;
    logic              idex_nop;
    logic [3:0]        fwd_sel;
`ifdef STALL_COUNT_EN
    logic [15:0]       stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    forward_stall_ctrl #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .mux_ctrl  (mux_ctrl),
        .flush     (flush),
        .ex_result (ex_result),
        .mem_rdata (mem_rdata),
        .op1_rf    (op1_rf),
        .op2_rf    (op2_rf),
        .op1_out   (op1_out),
        .op2_out   (op2_out),
        .pc_en     (pc_en),
        .ifid_en   (ifid_en),
        .idex_nop  (idex_nop),
        .fwd_sel   (fwd_sel)
`ifdef STALL_COUNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; mux_ctrl = 4'd0;
        ex_result = '0; mem_rdata = '0; op1_rf = RF1; op2_rf = RF2;
        step(); step();
        rst = 1'b0;
        #2;
        chk("rst_pc_en", pc_en, 1);
        chk("rst_ifid_en", ifid_en, 1);
        chk("rst_idex_nop", idex_nop, 0);
        chk("rst_fwd_sel", fwd_sel, 0);
        chk("rst_op1", op1_out, RF1);
        chk("rst_op2", op2_out, RF2);
`ifdef STALL_COUNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif

        // Idle: code 0, no freeze.
        for (int i = 0; i < 3; i++) begin
            step(); #2;
            chk("idle_fwd_sel", fwd_sel, 0);
            chk("idle_nop", idex_nop, 0);
            chk("idle_op1", op1_out, RF1);
        end

        // EX->EX forwarding via res_q1 / res_q2.
        step(); ex_result = 16'h1234; mux_ctrl = 4'd1;
        step(); ex_result = 16'h5555; mux_ctrl = 4'd4; #2;
        chk("fwd1_sel", fwd_sel, 1);
        chk("fwd1_op1", op1_out, 16'h1234);
        chk("fwd1_op2", op2_out, RF2);
        step(); ex_result = 16'h7777; mux_ctrl = 4'd3; #2;
        chk("fwd4_op2", op2_out, 16'h1234);
        chk("fwd4_op1", op1_out, RF1);
        step(); ex_result = 16'h4242; mux_ctrl = 4'd2; #2;
        chk("fwd3_op1", op1_out, 16'h5555);
        chk("fwd3_op2", op2_out, RF2);
        step(); ex_result = 16'h0000; mux_ctrl = 4'd5; #2;
        chk("fwd2_op2", op2_out, 16'h4242);
        chk("fwd2_op1", op1_out, RF1);
        step(); mux_ctrl = 4'd9; #2;
        chk("code5_nofreeze_sel", fwd_sel, 0);
        chk("code5_op2", op2_out, RF2);
        step(); mux_ctrl = 4'd0; #2;
        chk("code9_sel", fwd_sel, 0);
        chk("code9_op1", op1_out, RF1);

        // Load-use with code 6: one bubble, then op2 from ld_q. Decode inputs ignored in STALL.
        step(); freeze = 1'b1; mux_ctrl = 4'd6; #2;
        chk("lu_pc_en", pc_en, 0);
        chk("lu_ifid_en", ifid_en, 0);
        chk("lu_nop", idex_nop, 1);
        step(); mux_ctrl = 4'd1; mem_rdata = 16'hBEEF; #2;
        chk("lu_stall_pc_en", pc_en, 1);
        chk("lu_stall_ifid", ifid_en, 1);
        chk("lu_stall_nop", idex_nop, 0);
        chk("lu_stall_sel", fwd_sel, 0);
        step(); freeze = 1'b0; mux_ctrl = 4'd0; mem_rdata = '0; #2;
        chk("lu_sel8", fwd_sel, 8);
        chk("lu_op2", op2_out, 16'hBEEF);
        chk("lu_op1", op1_out, RF1);
        chk("lu_run_pc_en", pc_en, 1);

        // Flush during STALL kills the pending load forward.
        step(); freeze = 1'b1; mux_ctrl = 4'd6; #2;
        chk("fs_pc_en", pc_en, 0);
        step(); freeze = 1'b0; mux_ctrl = 4'd0; flush = 1'b1; mem_rdata = 16'hDEAD; #2;
        chk("fs_nop", idex_nop, 1);
        chk("fs_pc_en_stall", pc_en, 1);
        step(); flush = 1'b0; mem_rdata = '0; #2;
        chk("fs_sel", fwd_sel, 0);
        chk("fs_op1", op1_out, RF1);
        chk("fs_op2", op2_out, RF2);
        freeze = 1'b1; #2;
        chk("fs_back_in_run", pc_en, 0);
        freeze = 1'b0;

        // Flush and freeze together in RUN: flush wins, no stall.
        step(); flush = 1'b1; freeze = 1'b1; mux_ctrl = 4'd6; #2;
        chk("ff_nop", idex_nop, 1);
        chk("ff_pc_en", pc_en, 1);
        chk("ff_ifid_en", ifid_en, 1);
        step(); flush = 1'b0; freeze = 1'b0; mux_ctrl = 4'd0; #2;
        chk("ff_sel", fwd_sel, 0);
        freeze = 1'b1; #2;
        chk("ff_still_run", pc_en, 0);
        freeze = 1'b0;

        // Back-to-back load-use: code 5 then code 6.
        step(); freeze = 1'b1; mux_ctrl = 4'd5;
        step(); mux_ctrl = 4'd1; mem_rdata = 16'hCAFE; #2;
        chk("bb_stall_pc_en", pc_en, 1);
        chk("bb_stall_nop", idex_nop, 0);
        chk("bb_stall_sel", fwd_sel, 0);
        step(); mux_ctrl = 4'd6; mem_rdata = '0; #2;
        chk("bb_sel7", fwd_sel, 7);
        chk("bb_op1", op1_out, 16'hCAFE);
        chk("bb_pc_en2", pc_en, 0);
        chk("bb_nop2", idex_nop, 1);
        step(); freeze = 1'b0; mux_ctrl = 4'd0; mem_rdata = 16'hBEEF; #2;
        chk("bb_stall2_sel", fwd_sel, 0);
        chk("bb_stall2_op2", op2_out, RF2);
        step(); mem_rdata = '0; #2;
        chk("bb_sel8", fwd_sel, 8);
        chk("bb_op2", op2_out, 16'hBEEF);
        chk("bb_op1_rf", op1_out, RF1);
`ifdef STALL_COUNT_EN
        chk("cnt_4", stall_cnt, 4);
`endif

        // Reset in the middle of a STALL.
        step(); freeze = 1'b1; mux_ctrl = 4'd6;
        step(); freeze = 1'b0; mux_ctrl = 4'd0; rst = 1'b1; #2;
`ifdef STALL_COUNT_EN
        chk("cnt_5", stall_cnt, 5);
`endif
        step(); rst = 1'b0; #2;
        chk("rmid_sel", fwd_sel, 0);
        chk("rmid_pc_en", pc_en, 1);
        chk("rmid_ifid", ifid_en, 1);
        chk("rmid_nop", idex_nop, 0);
`ifdef STALL_COUNT_EN
        chk("rmid_cnt", stall_cnt, 0);
`endif
        step(); #2;
        chk("rmid_pend_gone", fwd_sel, 0);
        chk("rmid_op2", op2_out, RF2);

        // Three separate load-use stalls.
        for (int i = 0; i < 3; i++) begin
            step(); freeze = 1'b1; mux_ctrl = 4'd5;
            step(); freeze = 1'b0; mux_ctrl = 4'd0;
        end
        step(); #2;
        chk("three_sel", fwd_sel, 7);
`ifdef STALL_COUNT_EN
        chk("cnt_3", stall_cnt, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/forward_stall_ctrl.md
Name: forward_stall_ctrl

Overview:
- Executes the hazard decisions made in decode: consumes `freeze` and the 4-bit forwarding code.
- Drives the PC / IF-ID enables and the ID-EX bubble.
- Holds the result history registers and selects the forwarded operands presented to the EX stage.
- Sits between decode and execute; owns the ID-EX forwarding-select register and the load-use stall state machine.

Parameters:
- DATA_W, 16, width of operands, results and memory read data.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- freeze  input  1  load-use hazard request from the dependency detector (ID stage)
- mux_ctrl  input  4  forwarding code from the dependency detector (ID stage)
- flush  input  1  control-transfer taken (PC update); kills the instruction in ID
- ex_result  input  DATA_W  ALU result of the instruction currently in EX
- mem_rdata  input  DATA_W  load data returned this cycle
- op1_rf  input  DATA_W  register-file operand 1 of the instruction in EX
- op2_rf  input  DATA_W  register-file operand 2 of the instruction in EX
- op1_out  output  DATA_W  forwarded operand 1 to the ALU
- op2_out  output  DATA_W  forwarded operand 2 to the ALU
- pc_en  output  1  PC write enable
- ifid_en  output  1  IF-ID register enable
- idex_nop  output  1  load a NOP into ID-EX this cycle
- fwd_sel  output  4  registered forwarding code now applied in EX

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high.
- Reset values:
  - state = RUN; fwd_sel = 0; pend_sel = 0.
  - res_q1, res_q2, ld_q = 0; stall_cnt = 0.
  - Combinational outputs after reset: pc_en = 1, ifid_en = 1, idex_nop = 0.
- History registers, updated every cycle including during stalls:
  - res_q1 <= ex_result
  - res_q2 <= res_q1
  - ld_q <= mem_rdata
- States: RUN, STALL.
- RUN, flush=1 (flush has priority over freeze):
  - idex_nop=1, pc_en=1, ifid_en=1.
  - fwd_sel <= 0; pend_sel <= 0; stay in RUN.
- RUN, flush=0, freeze=1:
  - pc_en=0, ifid_en=0, idex_nop=1.
  - fwd_sel <= 0.
  - pend_sel <= remap(mux_ctrl), where 5->7, 6->8, any other code->0.
  - Go to STALL.
- RUN, flush=0, freeze=0:
  - pc_en=1, ifid_en=1, idex_nop=0.
  - fwd_sel <= mux_ctrl if the code is in {0,1,2,3,4,7,8}; otherwise 0.
- STALL lasts exactly one cycle:
  - pc_en=1, ifid_en=1, idex_nop=0.
  - mux_ctrl and freeze are ignored.
  - fwd_sel <= pend_sel; pend_sel <= 0; go to RUN.
- STALL with flush=1:
  - idex_nop=1; fwd_sel <= 0; pend_sel <= 0; go to RUN.
- EX operand mux (combinational from fwd_sel):
  - 1: op1=res_q1
  - 2: op2=res_q1
  - 3: op1=res_q2
  - 4: op2=res_q2
  - 7: op1=ld_q
  - 8: op2=ld_q
  - The operand not named by the code comes from the register file.
  - 0, 5, 6, 9-15: both operands from the register file.
- Latency:
  - Forwarding code sampled in ID is applied in EX one cycle later.
  - A load-use hazard costs exactly one bubble cycle.
  - The stalled instruction's operand then comes from ld_q, i.e. the load data registered in the bubble cycle.
- Back-to-back freeze: a freeze after STALL, with the detector seeing a real new load, starts a new stall; no stall is ever longer than 1 cycle per request.
- Reset mid-STALL: returns to RUN, pend_sel is discarded, no bubble is issued.

Optional Feature:
- Macro: STALL_COUNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Increments on every RUN->STALL transition; saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then mux_ctrl=0 and freeze=0 for 3 cycles -> pc_en=1, ifid_en=1, idex_nop=0, fwd_sel=0, op1_out=op1_rf, op2_out=op2_rf.
- ex_result=16'h1234 at cycle t; mux_ctrl=1 at t -> at t+1: fwd_sel=1, op1_out=16'h1234, op2_out=op2_rf. Repeat with code 4 at t+1 -> at t+2: op2_out=16'h1234 via res_q2.
- freeze=1, mux_ctrl=6 at t -> t: pc_en=0, ifid_en=0, idex_nop=1. t+1: STALL, fwd_sel=0. mem_rdata=16'hBEEF at t+1 -> t+2: fwd_sel=8, op2_out=16'hBEEF, state RUN.
- freeze=1 at t, flush=1 at t+1 (STALL) -> t+1: idex_nop=1. t+2: fwd_sel=0, op1_out=op1_rf, no forwarding of pending load.
- flush=1 and freeze=1 simultaneously in RUN -> idex_nop=1, pc_en=1, no transition to STALL; mux_ctrl=5 or 9 in RUN without freeze -> fwd_sel=0.
- With STALL_COUNT_EN: 3 separate load-use freezes -> stall_cnt=3; rst during STALL -> stall_cnt=0, fwd_sel=0, pc_en=1 next cycle.
